// File: rtl/forward_hazard_unit.sv
// Operand forwarding select and load-use stall control for the ID/EX boundary.
// For each source channel it picks the nearest in-flight producer (EX, MEM, WB)
// and registers that choice as the EX-stage mux select. It detects a load in
// EX feeding an ID operand and stalls for LOAD_STALL cycles. It also counts
// issued stall cycles in a saturating counter.
module forward_hazard_unit #(
    parameter int unsigned NUM_SRC    = 3,
    parameter int unsigned LOAD_STALL = 1,
    parameter int unsigned CNT_W      = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [5*NUM_SRC-1:0] src_id,
    input  logic [NUM_SRC-1:0]   src_used_id,
    input  logic [4:0]           rd_ex,
    input  logic [4:0]           rd_mem,
    input  logic [4:0]           rd_wb,
    input  logic                 rf_le_ex,
    input  logic                 rf_le_mem,
    input  logic                 rf_le_wb,
    input  logic                 load_ex,
    input  logic                 pipe_hold,
    input  logic                 flush,
    output logic [2*NUM_SRC-1:0] fwd_sel,
    output logic                 stall_id,
    output logic                 bubble_ex,
    output logic [CNT_W-1:0]     stall_cnt
);

    localparam int unsigned SEL_W = 2 * NUM_SRC;
    // Value of scnt on the last STALL-state cycle; STALL lasts LOAD_STALL-1 cycles.
    localparam int unsigned STALL_LAST = (LOAD_STALL > 2) ? (LOAD_STALL - 2) : 0;

    localparam logic [1:0] SEL_IDEX = 2'b00;
    localparam logic [1:0] SEL_MEM  = 2'b01;
    localparam logic [1:0] SEL_WB   = 2'b10;
    localparam logic [1:0] SEL_WB1  = 2'b11;

    typedef enum logic {
        RUN   = 1'b0,
        STALL = 1'b1
    } state_t;

    state_t           state, state_nxt;
    logic             scnt, scnt_nxt;
    logic [SEL_W-1:0] fwd_sel_nxt;
    logic [CNT_W-1:0] stall_cnt_nxt;

    logic [NUM_SRC-1:0] match_ex;
    logic [NUM_SRC-1:0] match_mem;
    logic [NUM_SRC-1:0] match_wb;
    logic [SEL_W-1:0]   sel_nxt;
    logic               hazard;
    logic               stall_req;

    // Per-channel producer matching; register 0 and unused channels never match.
    always_comb begin
        match_ex  = '0;
        match_mem = '0;
        match_wb  = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            match_ex[i]  = src_used_id[i] && rf_le_ex  && (rd_ex  != 5'd0)
                           && (rd_ex  == src_id[5*i +: 5]);
            match_mem[i] = src_used_id[i] && rf_le_mem && (rd_mem != 5'd0)
                           && (rd_mem == src_id[5*i +: 5]);
            match_wb[i]  = src_used_id[i] && rf_le_wb  && (rd_wb  != 5'd0)
                           && (rd_wb  == src_id[5*i +: 5]);
        end
    end

    // Nearest-stage-wins select per channel.
    always_comb begin
        sel_nxt = '0;
        for (int i = 0; i < int'(NUM_SRC); i++) begin
            if (match_ex[i]) begin
                sel_nxt[2*i +: 2] = SEL_MEM;
            end else if (match_mem[i]) begin
                sel_nxt[2*i +: 2] = SEL_WB;
            end else if (match_wb[i]) begin
                sel_nxt[2*i +: 2] = SEL_WB1;
            end else begin
                sel_nxt[2*i +: 2] = SEL_IDEX;
            end
        end
    end

    assign hazard = load_ex && (|match_ex);

    // Next-state, stall request and register updates; flush beats hold beats hazard.
    always_comb begin
        state_nxt     = state;
        scnt_nxt      = scnt;
        fwd_sel_nxt   = fwd_sel;
        stall_cnt_nxt = stall_cnt;
        stall_req     = 1'b0;

        if (flush) begin
            state_nxt   = RUN;
            scnt_nxt    = 1'b0;
            fwd_sel_nxt = '0;
        end else if (pipe_hold) begin
            state_nxt   = state;
        end else if (state == STALL) begin
            stall_req   = 1'b1;
            fwd_sel_nxt = '0;
            if (scnt == 1'(STALL_LAST)) begin
                state_nxt = RUN;
                scnt_nxt  = 1'b0;
            end else begin
                scnt_nxt  = scnt + 1'b1;
            end
        end else if (hazard) begin
            stall_req   = 1'b1;
            fwd_sel_nxt = '0;
            if (LOAD_STALL >= 2) begin
                state_nxt = STALL;
                scnt_nxt  = 1'b0;
            end
        end else begin
            fwd_sel_nxt = sel_nxt;
        end

        if (stall_req && (stall_cnt != '1)) begin
            stall_cnt_nxt = stall_cnt + CNT_W'(1);
        end
    end

    // Stall outputs are forced low while reset is asserted.
    assign stall_id  = stall_req & rst_n;
    assign bubble_ex = stall_req & rst_n;

    // State, select and statistics registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= RUN;
            scnt      <= 1'b0;
            fwd_sel   <= '0;
            stall_cnt <= '0;
        end else begin
            state     <= state_nxt;
            scnt      <= scnt_nxt;
            fwd_sel   <= fwd_sel_nxt;
            stall_cnt <= stall_cnt_nxt;
        end
    end

endmodule

// File: tb/tb_forward_hazard_unit.sv
// Bench for forward_hazard_unit: a LOAD_STALL=1 instance and a LOAD_STALL=2
// instance share stimulus. A behavioural model tracks each instance. The model
// uses remaining-stall counts and per-channel select codes.
module tb_forward_hazard_unit;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [14:0] src_id;
    logic [2:0]  src_used_id;
    logic [4:0]  rd_ex, rd_mem, rd_wb;
    logic        rf_le_ex, rf_le_mem, rf_le_wb;
    logic        load_ex, pipe_hold, flush;

    logic [5:0]  fwd_sel1, fwd_sel2;
    logic        stall_id1, stall_id2, bubble_ex1, bubble_ex2;
    logic [15:0] stall_cnt1;
    logic [2:0]  stall_cnt2;

    always #5 clk = ~clk;

    forward_hazard_unit #(.NUM_SRC(3), .LOAD_STALL(1), .CNT_W(16)) dut1 (
        .clk(clk), .rst_n(rst_n), .src_id(src_id), .src_used_id(src_used_id),
        .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
        .rf_le_ex(rf_le_ex), .rf_le_mem(rf_le_mem), .rf_le_wb(rf_le_wb),
        .load_ex(load_ex), .pipe_hold(pipe_hold), .flush(flush),
        .fwd_sel(fwd_sel1), .stall_id(stall_id1), .bubble_ex(bubble_ex1),
        .stall_cnt(stall_cnt1)
    );

    forward_hazard_unit #(.NUM_SRC(3), .LOAD_STALL(2), .CNT_W(3)) dut2 (
        .clk(clk), .rst_n(rst_n), .src_id(src_id), .src_used_id(src_used_id),
        .rd_ex(rd_ex), .rd_mem(rd_mem), .rd_wb(rd_wb),
        .rf_le_ex(rf_le_ex), .rf_le_mem(rf_le_mem), .rf_le_wb(rf_le_wb),
        .load_ex(load_ex), .pipe_hold(pipe_hold), .flush(flush),
        .fwd_sel(fwd_sel2), .stall_id(stall_id2), .bubble_ex(bubble_ex2),
        .stall_cnt(stall_cnt2)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model state per instance.
    int m_rem [2];
    int m_sel [2][3];
    int m_cnt [2];
    int m_ls  [2] = '{1, 2};
    int m_max [2] = '{65535, 7};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit is_match(int ch, int stage);
        logic [4:0] rd;
        logic       le;
        logic [4:0] src;
        src = src_id[5*ch +: 5];
        case (stage)
            0:       begin rd = rd_ex;  le = rf_le_ex;  end
            1:       begin rd = rd_mem; le = rf_le_mem; end
            default: begin rd = rd_wb;  le = rf_le_wb;  end
        endcase
        return src_used_id[ch] && le && (rd != 5'd0) && (rd == src);
    endfunction

    function automatic int nearest(int ch);
        for (int s = 0; s < 3; s++)
            if (is_match(ch, s)) return s + 1;
        return 0;
    endfunction

    function automatic bit load_use();
        bit h = 1'b0;
        for (int ch = 0; ch < 3; ch++)
            if (is_match(ch, 0)) h = 1'b1;
        return load_ex && h;
    endfunction

    function automatic bit exp_stall(int d);
        if (!rst_n || flush || pipe_hold) return 1'b0;
        return (m_rem[d] > 0) || load_use();
    endfunction

    function automatic logic [1:0] dut_sel(int d, int ch);
        return (d == 0) ? fwd_sel1[2*ch +: 2] : fwd_sel2[2*ch +: 2];
    endfunction

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_rem[d] = 0;
            m_cnt[d] = 0;
            for (int ch = 0; ch < 3; ch++) m_sel[d][ch] = 0;
        end
    endtask

    task automatic model_step();
        for (int d = 0; d < 2; d++) begin
            bit s;
            s = exp_stall(d);
            if (flush) begin
                m_rem[d] = 0;
                for (int ch = 0; ch < 3; ch++) m_sel[d][ch] = 0;
            end else if (!pipe_hold) begin
                if (s) begin
                    m_rem[d] = (m_rem[d] > 0) ? m_rem[d] - 1 : m_ls[d] - 1;
                    for (int ch = 0; ch < 3; ch++) m_sel[d][ch] = 0;
                end else begin
                    for (int ch = 0; ch < 3; ch++) m_sel[d][ch] = nearest(ch);
                end
            end
            if (s && m_cnt[d] < m_max[d]) m_cnt[d]++;
        end
    endtask

    // Called at a falling edge with inputs applied; compares, advances the model,
    // and returns at the next falling edge.
    task automatic run_cycle();
        if (!rst_n) model_reset();
        #1;
        check("d0_stall",  32'(stall_id1),  32'(exp_stall(0)));
        check("d0_bubble", 32'(bubble_ex1), 32'(exp_stall(0)));
        check("d1_stall",  32'(stall_id2),  32'(exp_stall(1)));
        check("d1_bubble", 32'(bubble_ex2), 32'(exp_stall(1)));
        check("d0_cnt", 32'(stall_cnt1), 32'(m_cnt[0]));
        check("d1_cnt", 32'(stall_cnt2), 32'(m_cnt[1]));
        for (int d = 0; d < 2; d++)
            for (int ch = 0; ch < 3; ch++)
                check($sformatf("d%0d_sel%0d", d, ch), 32'(dut_sel(d, ch)), 32'(m_sel[d][ch]));
        if (rst_n) model_step();
        @(negedge clk);
    endtask

    task automatic clr();
        src_id = '0; src_used_id = '0;
        rd_ex = '0; rd_mem = '0; rd_wb = '0;
        rf_le_ex = 1'b0; rf_le_mem = 1'b0; rf_le_wb = 1'b0;
        load_ex = 1'b0; pipe_hold = 1'b0; flush = 1'b0;
    endtask

    task automatic pulse_reset();
        rst_n = 1'b0;
        run_cycle();
        rst_n = 1'b1;
    endtask

    // Load in EX writing r9 consumed by ch0 in ID.
    task automatic load_use_setup();
        clr();
        load_ex = 1'b1; rd_ex = 5'd9; rf_le_ex = 1'b1;
        src_id[4:0] = 5'd9; src_used_id = 3'b001;
    endtask

    initial begin
        rst_n = 1'b0;
        clr();
        model_reset();
        @(negedge clk);
        run_cycle();
        rst_n = 1'b1;

        // ALU to ALU forwarding.
        clr();
        rd_ex = 5'd5; rf_le_ex = 1'b1; src_id[4:0] = 5'd5; src_used_id = 3'b001;
        run_cycle();
        check("alu_fwd", 32'(fwd_sel1[1:0]), 32'd1);

        // Nearest-stage priority on ch1.
        clr();
        rd_ex = 5'd7; rd_mem = 5'd7; rd_wb = 5'd7;
        rf_le_ex = 1'b1; rf_le_mem = 1'b1; rf_le_wb = 1'b1;
        src_id[9:5] = 5'd7; src_used_id = 3'b010;
        run_cycle();
        check("prio_ex", 32'(fwd_sel1[3:2]), 32'd1);
        rf_le_ex = 1'b0;
        run_cycle();
        check("prio_mem", 32'(fwd_sel1[3:2]), 32'd2);
        rf_le_mem = 1'b0;
        run_cycle();
        check("prio_wb", 32'(fwd_sel1[3:2]), 32'd3);

        // Load-use stall, then the held instruction sees the advanced stages.
        pulse_reset();
        load_use_setup();
        run_cycle();
        load_ex = 1'b0; rd_ex = 5'd0; rf_le_ex = 1'b0; rd_mem = 5'd9; rf_le_mem = 1'b1;
        run_cycle();
        check("ls1_after", 32'(fwd_sel1[1:0]), 32'd2);
        rd_mem = 5'd0; rf_le_mem = 1'b0; rd_wb = 5'd9; rf_le_wb = 1'b1;
        run_cycle();
        check("ls2_after", 32'(fwd_sel2[1:0]), 32'd3);
        check("ls1_count", 32'(stall_cnt1), 32'd1);
        check("ls2_count", 32'(stall_cnt2), 32'd2);

        // Hold in the middle of the two-cycle stall extends it.
        clr();
        run_cycle();
        load_use_setup();
        run_cycle();
        load_ex = 1'b0; rd_ex = 5'd0; rf_le_ex = 1'b0; pipe_hold = 1'b1;
        repeat (3) run_cycle();
        pipe_hold = 1'b0;
        #1;
        check("hold_ext", 32'(stall_id2), 32'd1);
        run_cycle();

        // Register 0 and unused channels.
        clr();
        load_ex = 1'b1; rf_le_ex = 1'b1; src_used_id = 3'b001;
        run_cycle();
        rd_ex = 5'd4; src_id[4:0] = 5'd4; src_used_id = 3'b110;
        run_cycle();

        // Flush on the detection cycle.
        load_use_setup();
        flush = 1'b1;
        run_cycle();
        clr();
        run_cycle();

        // Reset in the middle of STALL aborts it immediately.
        load_use_setup();
        src_id[9:5] = 5'd3; rd_mem = 5'd3; rf_le_mem = 1'b1; src_used_id = 3'b011;
        run_cycle();
        #1;
        check("in_stall", 32'(stall_id2), 32'd1);
        rst_n = 1'b0;
        #1;
        check("rst_stall", 32'(stall_id2), 32'd0);
        check("rst_bubble", 32'(bubble_ex2), 32'd0);
        check("rst_cnt", 32'(stall_cnt2), 32'd0);
        model_reset();
        @(negedge clk);
        rst_n = 1'b1;
        clr();
        run_cycle();

        // Randomized traffic with hazards, holds, flushes and occasional resets.
        for (int n = 0; n < 600; n++) begin
            for (int ch = 0; ch < 3; ch++) src_id[5*ch +: 5] = 5'($urandom_range(0, 3));
            src_used_id = 3'($urandom);
            rd_ex  = 5'($urandom_range(0, 3));
            rd_mem = 5'($urandom_range(0, 3));
            rd_wb  = 5'($urandom_range(0, 3));
            rf_le_ex  = ($urandom_range(0, 9) < 8);
            rf_le_mem = ($urandom_range(0, 9) < 8);
            rf_le_wb  = ($urandom_range(0, 9) < 8);
            load_ex   = ($urandom_range(0, 9) < 5);
            pipe_hold = ($urandom_range(0, 9) < 2);
            flush     = ($urandom_range(0, 19) < 2);
            rst_n     = ($urandom_range(0, 99) != 0);
            run_cycle();
        end
        rst_n = 1'b1;
        clr();
        run_cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
